// File: rtl/rv_pipe_pkg.sv
// Shared RV64I pipeline definitions: opcodes, forward-select codes and the
// hazard controller's shadow-slot records.
package rv_pipe_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       u1;
    logic       u2;
    logic       wr;
    logic       load;
  } reg_use_t;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wr;
    logic       load;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
  } ex_slot_t;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wr;
    logic       load;
  } mem_slot_t;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wr;
  } wb_slot_t;

  // The nearer producer (EX/MEM) always wins over MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
    if (mem_hit)     return FWD_EXMEM;
    else if (wb_hit) return FWD_MEMWB;
    else             return FWD_RF;
  endfunction

endpackage

// File: rtl/rv_reg_use.sv
// Register-use decode: which source registers an instruction reads and
// whether it writes a non-zero destination.
module rv_reg_use
  import rv_pipe_pkg::*;
(
  input  logic [31:0] instr,
  output reg_use_t    ru
);

  logic [6:0] opcode;
  logic       writes_rd;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign unused_fields = ^{instr[31:25], instr[14:12]};

  always_comb begin
    ru        = '0;
    writes_rd = 1'b0;
    ru.rd     = instr[11:7];
    ru.rs1    = instr[19:15];
    ru.rs2    = instr[24:20];
    case (opcode)
      OP_R:      begin ru.u1 = 1'b1; ru.u2 = 1'b1; writes_rd = 1'b1; end
      OP_IMM:    begin ru.u1 = 1'b1; writes_rd = 1'b1; end
      OP_LOAD:   begin ru.u1 = 1'b1; writes_rd = 1'b1; ru.load = 1'b1; end
      OP_STORE:  begin ru.u1 = 1'b1; ru.u2 = 1'b1; end
      OP_BRANCH: begin ru.u1 = 1'b1; ru.u2 = 1'b1; end
      OP_JALR:   begin ru.u1 = 1'b1; writes_rd = 1'b1; end
      OP_JAL, OP_LUI, OP_AUIPC: writes_rd = 1'b1;
      default:   ;
    endcase
    // x0 is never a producer, so it can never raise a hazard or forward.
    ru.wr = writes_rd & (instr[11:7] != 5'd0);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadow EX/MEM/WB register-use slots, load-use
// stall and branch-flush sequencing, forwarding selects, ID bypass, counters.
module hazard_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      id_instr,
  input  logic             id_valid,
  input  logic             br_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             id_byp_a,
  output logic             id_byp_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  reg_use_t  id_ru;
  ex_slot_t  ex_q;
  mem_slot_t mem_q;
  wb_slot_t  wb_q;
  logic      lu;
  logic      unused_mem_load;

  assign unused_mem_load = mem_q.load;

  rv_reg_use u_reg_use (
    .instr (id_instr),
    .ru    (id_ru)
  );

  assign lu = id_valid & ex_q.v & ex_q.load & ex_q.wr &
              ((id_ru.u1 & (id_ru.rs1 == ex_q.rd)) |
               (id_ru.u2 & (id_ru.rs2 == ex_q.rd)));

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (br_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (lu) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  assign fwd_a = fwd_sel(mem_q.v & mem_q.wr & (mem_q.rd == ex_q.rs1) & ex_q.u1,
                         wb_q.v  & wb_q.wr  & (wb_q.rd  == ex_q.rs1) & ex_q.u1);
  assign fwd_b = fwd_sel(mem_q.v & mem_q.wr & (mem_q.rd == ex_q.rs2) & ex_q.u2,
                         wb_q.v  & wb_q.wr  & (wb_q.rd  == ex_q.rs2) & ex_q.u2);

  assign id_byp_a = wb_q.v & wb_q.wr & (wb_q.rd == id_ru.rs1) & id_ru.u1;
  assign id_byp_b = wb_q.v & wb_q.wr & (wb_q.rd == id_ru.rs2) & id_ru.u2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      wb_q  <= '{v: mem_q.v, rd: mem_q.rd, wr: mem_q.wr};
      mem_q <= '{v: ex_q.v, rd: ex_q.rd, wr: ex_q.wr, load: ex_q.load};
      // A bubble zeroes every field so a held instruction's register numbers
      // cannot steer the forward selects while its slot is empty.
      if (idex_bubble) begin
        ex_q <= '0;
      end else begin
        ex_q <= '{v: id_valid, rd: id_ru.rd, wr: id_ru.wr, load: id_ru.load,
                  rs1: id_ru.rs1, rs2: id_ru.rs2, u1: id_ru.u1, u2: id_ru.u2};
      end
      if (lu && !br_taken && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (br_taken && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares.
module tb_hazard_ctrl;

  localparam logic [3:0] C_RUN   = 4'b1100;  // {pc_write, ifid_write, ifid_flush, idex_bubble}
  localparam logic [3:0] C_STALL = 4'b0001;
  localparam logic [3:0] C_FLUSH = 4'b1111;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sat_rst_n;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        br_taken;
  logic        sat_br;

  logic        pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [1:0]  fwd_a, fwd_b;
  logic        id_byp_a, id_byp_b;
  logic [31:0] stall_cnt, flush_cnt;

  logic [1:0]  sat_flush;
  logic [1:0]  unused_sat_stall, unused_sat_fa, unused_sat_fb;
  logic        unused_sat_pc, unused_sat_ifw, unused_sat_ifl, unused_sat_bub;
  logic        unused_sat_ba, unused_sat_bb;

  typedef logic [75:0] vec_t;
  vec_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .id_instr(id_instr), .id_valid(id_valid),
    .br_taken(br_taken), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .fwd_a(fwd_a),
    .fwd_b(fwd_b), .id_byp_a(id_byp_a), .id_byp_b(id_byp_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(sat_rst_n), .id_instr(id_instr), .id_valid(id_valid),
    .br_taken(sat_br), .pc_write(unused_sat_pc), .ifid_write(unused_sat_ifw),
    .ifid_flush(unused_sat_ifl), .idex_bubble(unused_sat_bub), .fwd_a(unused_sat_fa),
    .fwd_b(unused_sat_fb), .id_byp_a(unused_sat_ba), .id_byp_b(unused_sat_bb),
    .stall_cnt(unused_sat_stall), .flush_cnt(sat_flush)
  );

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [6:0] f7);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_ld(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b011, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] enc_sd(input logic [4:0] rs2, input logic [4:0] rs1);
    return {7'd0, rs2, rs1, 3'b011, 5'd0, 7'b0100011};
  endfunction

  // One cycle of stimulus plus the outputs expected during that cycle.
  task automatic step(input string nm, input logic rn, input logic [31:0] ins,
                      input logic v, input logic br, input logic sbr,
                      input logic [3:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                      input logic ba, input logic bb, input int unsigned sc,
                      input int unsigned fc, input logic [1:0] sf);
    @(posedge clk);
    #1;
    reset_n   = rn;
    sat_rst_n = 1'b1;
    id_instr  = ins;
    id_valid  = v;
    br_taken  = br;
    sat_br    = sbr;
    exp_q.push_back({ctl, fa, fb, ba, bb, 32'(sc), 32'(fc), sf});
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t  e;
      vec_t  a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b,
           id_byp_a, id_byp_b, stall_cnt, flush_cnt, sat_flush};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got %h want %h (ctl/fa/fb/byp/stall/flush/satflush)", n, a, e);
      end
    end
  end

  initial begin
    logic [31:0] ld_x5_x1, add_x6, add_x3, sub_x4, ld_x0, add_x1, ld_x5_x2;
    logic [31:0] add_x7, sd_x7, ld_x9, add_x10;
    ld_x5_x1 = enc_ld(5'd5, 5'd1);
    add_x6   = enc_r(5'd6, 5'd5, 5'd1, 7'd0);
    add_x3   = enc_r(5'd3, 5'd1, 5'd2, 7'd0);
    sub_x4   = enc_r(5'd4, 5'd3, 5'd3, 7'b0100000);
    ld_x0    = enc_ld(5'd0, 5'd1);
    add_x1   = enc_r(5'd1, 5'd0, 5'd0, 7'd0);
    ld_x5_x2 = enc_ld(5'd5, 5'd2);
    add_x7   = enc_r(5'd7, 5'd1, 5'd2, 7'd0);
    sd_x7    = enc_sd(5'd7, 5'd8);
    ld_x9    = enc_ld(5'd9, 5'd1);
    add_x10  = enc_r(5'd10, 5'd9, 5'd9, 7'd0);

    reset_n = 1'b0; sat_rst_n = 1'b0;
    id_instr = '0; id_valid = 1'b0; br_taken = 1'b0; sat_br = 1'b0;
    repeat (3) @(posedge clk);

    step("reset_out",   1, 32'd0,    0, 0, 0, C_RUN,   2'b00, 2'b00, 0, 0, 0, 0, 2'd0);
    // load then dependent use
    step("lu_issue_ld", 1, ld_x5_x1, 1, 0, 0, C_RUN,   2'b00, 2'b00, 0, 0, 0, 0, 2'd0);
    step("lu_stall",    1, add_x6,   1, 0, 0, C_STALL, 2'b00, 2'b00, 0, 0, 0, 0, 2'd0);
    step("lu_release",  1, add_x6,   1, 0, 0, C_RUN,   2'b00, 2'b00, 0, 0, 1, 0, 2'd0);
    step("lu_fwd_wb",   1, 32'd0,    0, 0, 0, C_RUN,   2'b01, 2'b00, 0, 0, 1, 0, 2'd0);
    step("lu_drain",    1, 32'd0,    0, 0, 0, C_RUN,   2'b00, 2'b00, 0, 0, 1, 0, 2'd0);
    // back-to-back ALU dependency
    step("alu_add",     1, add_x3,   1, 0, 0, C_RUN,   2'b00, 2'b00, 0, 0, 1, 0, 2'd0);
    step("alu_sub",     1, sub_x4,   1, 0, 0, C_RUN,   2'b00, 2'b00, 0, 0, 1, 0, 2'd0);
    step("alu_fwd_mem", 1, 32'd0,    0, 0, 0, C_RUN,   2'b10, 2'b10, 0, 0, 1, 0, 2'd0);
    step("alu_drain",   1, 32'd0,    0, 0, 0, C_RUN,   2'b00, 2'b00, 0, 0, 1, 0, 2'd0);
    // x0 destination
    step("x0_ld",       1, ld_x0,    1, 0, 0, C_RUN,   2'b00, 2'b00, 0, 0, 1, 0, 2'd0);
    step("x0_use",      1, add_x1,   1, 0, 0, C_RUN,   2'b00, 2'b00, 0, 0, 1, 0, 2'd0);
    step("x0_no_fwd",   1, 32'd0,    0, 0, 0, C_RUN,   2'b00, 2'b00, 0, 0, 1, 0, 2'd0);
    step("x0_drain",    1, 32'd0,    0, 0, 0, C_RUN,   2'b00, 2'b00, 0, 0, 1, 0, 2'd0);
    // branch coinciding with load-use
    step("br_ld",       1, ld_x5_x2, 1, 0, 0, C_RUN,   2'b00, 2'b00, 0, 0, 1, 0, 2'd0);
    step("br_and_lu",   1, add_x6,   1, 1, 0, C_FLUSH, 2'b00, 2'b00, 0, 0, 1, 0, 2'd0);
    step("br_after",    1, 32'd0,    0, 0, 0, C_RUN,   2'b00, 2'b00, 0, 0, 1, 1, 2'd0);
    // WB write of x7 read by a store in ID
    step("byp_add_x7",  1, add_x7,   1, 0, 0, C_RUN,   2'b00, 2'b00, 0, 0, 1, 1, 2'd0);
    step("byp_gap1",    1, 32'd0,    0, 0, 0, C_RUN,   2'b00, 2'b00, 0, 0, 1, 1, 2'd0);
    step("byp_gap2",    1, 32'd0,    0, 0, 0, C_RUN,   2'b00, 2'b00, 0, 0, 1, 1, 2'd0);
    step("byp_store",   1, sd_x7,    1, 0, 0, C_RUN,   2'b00, 2'b00, 0, 1, 1, 1, 2'd0);
    step("byp_drain",   1, 32'd0,    0, 0, 0, C_RUN,   2'b00, 2'b00, 0, 0, 1, 1, 2'd0);
    // reset during a stall, then during a flush
    step("rst_ld",      1, ld_x9,    1, 0, 0, C_RUN,   2'b00, 2'b00, 0, 0, 1, 1, 2'd0);
    step("rst_in_stall",0, add_x10,  1, 0, 0, C_STALL, 2'b00, 2'b00, 0, 0, 1, 1, 2'd0);
    step("rst_no_resid",1, add_x10,  1, 0, 0, C_RUN,   2'b00, 2'b00, 0, 0, 0, 0, 2'd0);
    step("rst_in_flush",0, add_x10,  1, 1, 0, C_FLUSH, 2'b00, 2'b00, 0, 0, 0, 0, 2'd0);
    step("rst_after_fl",1, 32'd0,    0, 0, 0, C_RUN,   2'b00, 2'b00, 0, 0, 0, 0, 2'd0);
    // saturation of the narrow flush counter
    step("sat_0",       1, 32'd0,    0, 0, 1, C_RUN,   2'b00, 2'b00, 0, 0, 0, 0, 2'd0);
    step("sat_1",       1, 32'd0,    0, 0, 1, C_RUN,   2'b00, 2'b00, 0, 0, 0, 0, 2'd1);
    step("sat_2",       1, 32'd0,    0, 0, 1, C_RUN,   2'b00, 2'b00, 0, 0, 0, 0, 2'd2);
    step("sat_3",       1, 32'd0,    0, 0, 1, C_RUN,   2'b00, 2'b00, 0, 0, 0, 0, 2'd3);
    step("sat_hold",    1, 32'd0,    0, 0, 1, C_RUN,   2'b00, 2'b00, 0, 0, 0, 0, 2'd3);
    step("sat_hold2",   1, 32'd0,    0, 0, 0, C_RUN,   2'b00, 2'b00, 0, 0, 0, 0, 2'd3);

    for (int i = 0; i < 4; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV64I datapath. It sits beside the instruction-decode stage and keeps a shadow pipeline of register-use metadata for EX, MEM and WB. From that it detects load-use hazards, sequences stalls and branch flushes, drives the EX-stage forwarding-mux selects, and drives the ID-stage register-file bypass. It also keeps saturating stall and flush event counters for performance analysis.

## Interface
Parameters:
- CNT_W, 32, width of the stall and flush event counters

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset_n  in  1  synchronous reset, active low
- id_instr  in  32  instruction currently held in the IF/ID register
- id_valid  in  1  id_instr is a real instruction, not a bubble
- br_taken  in  1  the branch or jump currently in EX resolved taken (redirect)
- pc_write  out  1  PC register enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  clear the IF/ID register to a bubble
- idex_bubble  out  1  load a bubble (control fields zero) into ID/EX
- fwd_a  out  2  EX operand A select: 00 register file, 10 EX/MEM result, 01 MEM/WB result
- fwd_b  out  2  EX operand B select, same encoding as fwd_a
- id_byp_a  out  1  ID rs1 read takes the WB write data (same-cycle write/read)
- id_byp_b  out  1  ID rs2 read takes the WB write data
- stall_cnt  out  CNT_W  number of load-use stall cycles
- flush_cnt  out  CNT_W  number of branch flush events

## Operation
- ID decode is from id_instr: opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20].
- Register use by opcode:
  - R (0110011): rs1, rs2, rd
  - I-ALU (0010011): rs1, rd
  - LOAD (0000011): rs1, rd; load=1
  - STORE (0100011): rs1, rs2
  - BRANCH (1100011): rs1, rs2
  - JALR (1100111): rs1, rd
  - JAL (1101111), LUI (0110111), AUIPC (0010111): rd only
  - Any other opcode: no use.
  - wr=1 only if the opcode writes rd and rd != 0.
- Shadow slots hold the following fields:
  - EX: {v, rd, wr, load, rs1, rs2, u1, u2}
  - MEM: {v, rd, wr, load}
  - WB: {v, rd, wr}
- Load-use hazard (lu) = id_valid & EX.v & EX.load & EX.wr & ((u1 & rs1==EX.rd) | (u2 & rs2==EX.rd)).
- Priority: br_taken over lu.
  - br_taken: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1. No stall is counted.
  - lu, no br_taken: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
  - Otherwise: pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0.
- Slot advance every clock:
  - MEM<=EX, WB<=MEM.
  - EX<=decoded ID fields with v=id_valid, unless idex_bubble, in which case EX.v<=0.
- Forwarding:
  - fwd_a=10 if MEM.v & MEM.wr & MEM.rd==EX.rs1 & EX.u1.
  - Else fwd_a=01 if WB.v & WB.wr & WB.rd==EX.rs1 & EX.u1.
  - Else fwd_a=00.
  - fwd_b is the same using rs2/u2. MEM beats WB.
- Bypass: id_byp_a = WB.v & WB.wr & WB.rd==rs1 & u1; id_byp_b likewise for rs2/u2.
- Counters, both saturating at all-ones:
  - stall_cnt += 1 on each cycle with lu & !br_taken.
  - flush_cnt += 1 on each cycle with br_taken.
- x0 is never a hazard or forward source; the wr qualification guarantees this.

## Timing
- All control outputs are combinational from the current slots plus id_instr, id_valid and br_taken, so they are valid in the same cycle. Counters update at the edge and are visible the next cycle.
- A load-use stall lasts exactly 1 cycle. On the next cycle the load is in MEM, lu deasserts, and fwd selects 01 once the dependent instruction reaches EX.
- A back-to-back dependent pair without a load gives zero stall and fwd=10 on the next cycle.
- Reset (reset_n low at an edge):
  - All slot v<=0 and counters<=0.
  - The following cycle's outputs: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, fwd_a=fwd_b=00, id_byp_a=id_byp_b=0.
- Reset asserted mid-stall or mid-flush discards the in-flight slots with no residual stall.
- br_taken and lu in the same cycle: flush only, stall_cnt unchanged.

## Structure
- Package rv_pipe_pkg holds:
  - opcode localparams
  - FWD_RF=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01
  - the shadow-slot struct typedefs
- Sub-module rv_reg_use (combinational): instruction -> {rs1, rs2, rd, u1, u2, wr, load}.
- hazard_ctrl holds the slots, the hazard and forward logic, and the counters.

## Test plan
- Dependent load then use: ld x5 followed by add x6,x5,x1 -> lu for 1 cycle, then fwd_a=01, stall_cnt=1.
- Dependent ALU ops: add x3,x1,x2 followed by sub x4,x3,x3 -> no stall, fwd_a=fwd_b=10.
- x0 destination: ld x0 followed by add x1,x0,x0 -> no stall, fwd=00.
- Branch taken coinciding with a load-use hazard -> ifid_flush=1, idex_bubble=1, pc_write=1, flush_cnt=1, stall_cnt=0.
- WB write to x7 while ID reads rs2=x7 (store) -> id_byp_b=1, id_byp_a=0.
- Reset mid-stall, and counter saturation with a forced all-ones value -> outputs return to reset values and the counter holds all-ones.
